// File: rtl/placement_pkg.sv
// Shared constants and FSM encoding for the placement wirelength scorer.
package placement_pkg;

   localparam int DATA_W     = 32;
   localparam int N0_DEF     = 4;
   localparam int N_EDGE_DEF = 15;

   // Coordinate value that marks a node as not yet placed.
   localparam logic signed [DATA_W-1:0] UNPLACED = '1;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      EDGE = 3'd1,
      POSA = 3'd2,
      POSB = 3'd3,
      ACC  = 3'd4,
      DONE = 3'd5
   } state_e;

endpackage

// File: rtl/manhattan_len.sv
// Per-edge wirelength |dx| + |dy| - 1, with same-cell and unplaced-endpoint flags.
module manhattan_len
   import placement_pkg::*;
#(
   parameter int DATA_W = placement_pkg::DATA_W
) (
   input  logic signed [DATA_W-1:0] ax_i,
   input  logic signed [DATA_W-1:0] ay_i,
   input  logic signed [DATA_W-1:0] bx_i,
   input  logic signed [DATA_W-1:0] by_i,
   output logic signed [DATA_W-1:0] len_o,
   output logic                     zero_o,
   output logic                     unplaced_o
);

   localparam logic signed [DATA_W-1:0] UNPL = DATA_W'(UNPLACED);
   localparam logic signed [DATA_W-1:0] ONE  = DATA_W'(1);

   logic signed [DATA_W-1:0] dx;
   logic signed [DATA_W-1:0] dy;
   logic signed [DATA_W-1:0] adx;
   logic signed [DATA_W-1:0] ady;

   always_comb begin
      dx         = ax_i - bx_i;
      dy         = ay_i - by_i;
      adx        = dx[DATA_W-1] ? -dx : dx;
      ady        = dy[DATA_W-1] ? -dy : dy;
      len_o      = adx + ady - ONE;
      zero_o     = (dx == '0) && (dy == '0);
      unplaced_o = (ax_i == UNPL) || (ay_i == UNPL) ||
                   (bx_i == UNPL) || (by_i == UNPL);
   end

endmodule

// File: rtl/placement_eval.sv
// Walks the edge list of a finished placement and reports total/max wirelength and error flags.
// Build option PLACEMENT_EVAL_BOUNDS_EN adds bounds_err for coordinates outside the grid.
//
//   state | meaning
//   IDLE  | waiting for start; results held
//   EDGE  | read e_a[i], e_b[i]
//   POSA  | node ids back; read position of endpoint a
//   POSB  | a position back; read position of endpoint b
//   ACC   | b position back; score edge, advance i
//   DONE  | one-cycle done pulse
module placement_eval
   import placement_pkg::*;
#(
   parameter int N0     = N0_DEF,
   parameter int N_EDGE = N_EDGE_DEF,
   parameter int ADDR_W = 32,
   parameter int DATA_W = placement_pkg::DATA_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     ea_re,
   output logic                     eb_re,
   output logic [ADDR_W-1:0]        ea_addr,
   output logic [ADDR_W-1:0]        eb_addr,
   input  logic signed [DATA_W-1:0] ea_data,
   input  logic signed [DATA_W-1:0] eb_data,
   output logic                     px_re,
   output logic                     py_re,
   output logic [ADDR_W-1:0]        px_addr,
   output logic [ADDR_W-1:0]        py_addr,
   input  logic signed [DATA_W-1:0] px_data,
   input  logic signed [DATA_W-1:0] py_data,
   output logic signed [DATA_W-1:0] cost,
   output logic signed [DATA_W-1:0] max_len,
   output logic                     unplaced_err,
   output logic                     overlap_err
`ifdef PLACEMENT_EVAL_BOUNDS_EN
   ,
   output logic                     bounds_err
`endif
);

   localparam logic [ADDR_W-1:0] I_LAST = ADDR_W'(N_EDGE - 1);
   localparam logic [ADDR_W-1:0] I_ONE  = ADDR_W'(1);

   if (N_EDGE < 1) begin : g_bad_n_edge
      $error("placement_eval: N_EDGE must be at least 1");
   end
   if ((N0 < 1) || (N0 > 64)) begin : g_bad_n0
      $error("placement_eval: N0 must be in 1..64");
   end

   state_e                   state_q, state_d;
   logic [ADDR_W-1:0]        i_q;
   logic [ADDR_W-1:0]        e_addr_q;
   logic [ADDR_W-1:0]        p_addr_q;
   logic signed [DATA_W-1:0] ax_q, ay_q;
   logic signed [DATA_W-1:0] cost_q, max_q;
   logic                     unpl_q, ovl_q;

   logic signed [DATA_W-1:0] m_len;
   logic                     m_zero;
   logic                     m_unpl;
   logic                     oob;

   // b's position arrives during ACC, straight off the read ports.
   manhattan_len #(
      .DATA_W (DATA_W)
   ) u_len (
      .ax_i       (ax_q),
      .ay_i       (ay_q),
      .bx_i       (px_data),
      .by_i       (py_data),
      .len_o      (m_len),
      .zero_o     (m_zero),
      .unplaced_o (m_unpl)
   );

`ifdef PLACEMENT_EVAL_BOUNDS_EN
   localparam logic signed [DATA_W-1:0] COORD_MAX = DATA_W'(N0 - 1);
   localparam logic signed [DATA_W-1:0] UNPL      = DATA_W'(UNPLACED);

   logic bnd_q;

   function automatic logic coord_oob(input logic signed [DATA_W-1:0] c);
      return (c != UNPL) && (c[DATA_W-1] || (c > COORD_MAX));
   endfunction

   assign oob        = coord_oob(ax_q) | coord_oob(ay_q) |
                       coord_oob(px_data) | coord_oob(py_data);
   assign bounds_err = bnd_q;
`else
   assign oob = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = EDGE;
         EDGE:    state_d = POSA;
         POSA:    state_d = POSB;
         POSB:    state_d = ACC;
         ACC:     state_d = (i_q == I_LAST) ? DONE : EDGE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         i_q      <= '0;
         e_addr_q <= '0;
         p_addr_q <= '0;
         ax_q     <= '0;
         ay_q     <= '0;
         cost_q   <= '0;
         max_q    <= '0;
         unpl_q   <= 1'b0;
         ovl_q    <= 1'b0;
`ifdef PLACEMENT_EVAL_BOUNDS_EN
         bnd_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (start) begin
                  i_q    <= '0;
                  cost_q <= '0;
                  max_q  <= '0;
                  unpl_q <= 1'b0;
                  ovl_q  <= 1'b0;
`ifdef PLACEMENT_EVAL_BOUNDS_EN
                  bnd_q  <= 1'b0;
`endif
               end
            end
            EDGE: e_addr_q <= i_q;
            // The b address is captured here so POSB can drive it from a register.
            POSA: p_addr_q <= ADDR_W'(eb_data);
            POSB: begin
               ax_q <= px_data;
               ay_q <= py_data;
            end
            ACC: begin
               i_q <= i_q + I_ONE;
`ifdef PLACEMENT_EVAL_BOUNDS_EN
               if (oob) bnd_q <= 1'b1;
`endif
               if (m_unpl) begin
                  unpl_q <= 1'b1;
               end else if (m_zero) begin
                  ovl_q <= 1'b1;
               end else if (!oob) begin
                  cost_q <= cost_q + m_len;
                  if (m_len > max_q) max_q <= m_len;
               end
            end
            default: ;
         endcase
      end
   end

   // Addresses are live only in their issuing state and otherwise hold the last issued value.
   always_comb begin
      ea_re   = (state_q == EDGE);
      eb_re   = (state_q == EDGE);
      ea_addr = (state_q == EDGE) ? i_q : e_addr_q;
      eb_addr = ea_addr;
      px_re   = (state_q == POSA) || (state_q == POSB);
      py_re   = px_re;
      px_addr = (state_q == POSA) ? ADDR_W'(ea_data) : p_addr_q;
      py_addr = px_addr;
   end

   assign busy         = (state_q == EDGE) || (state_q == POSA) ||
                         (state_q == POSB) || (state_q == ACC);
   assign done         = (state_q == DONE);
   assign cost         = cost_q;
   assign max_len      = max_q;
   assign unplaced_err = unpl_q;
   assign overlap_err  = ovl_q;

endmodule

// File: tb/tb_placement_eval.sv
// Bench for placement_eval: directed scenarios plus randomized placements scored by a reference model.
module tb_placement_eval;

   localparam int N0     = 4;
   localparam int N_EDGE = 3;
   localparam int AW     = 32;
   localparam int DW     = 32;
   localparam int LAT    = 4 * N_EDGE + 1;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 start;
   logic                 busy, done;
   logic                 ea_re, eb_re, px_re, py_re;
   logic [AW-1:0]        ea_addr, eb_addr, px_addr, py_addr;
   logic signed [DW-1:0] ea_data, eb_data, px_data, py_data;
   logic signed [DW-1:0] cost, max_len;
   logic                 unplaced_err, overlap_err;
`ifdef PLACEMENT_EVAL_BOUNDS_EN
   logic                 bounds_err;
   bit                   exp_bnd;
`endif

   int e_a[16];
   int e_b[16];
   int pos_x[16];
   int pos_y[16];
   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   placement_eval #(
      .N0     (N0),
      .N_EDGE (N_EDGE),
      .ADDR_W (AW),
      .DATA_W (DW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .ea_re        (ea_re),
      .eb_re        (eb_re),
      .ea_addr      (ea_addr),
      .eb_addr      (eb_addr),
      .ea_data      (ea_data),
      .eb_data      (eb_data),
      .px_re        (px_re),
      .py_re        (py_re),
      .px_addr      (px_addr),
      .py_addr      (py_addr),
      .px_data      (px_data),
      .py_data      (py_data),
      .cost         (cost),
      .max_len      (max_len),
      .unplaced_err (unplaced_err),
      .overlap_err  (overlap_err)
`ifdef PLACEMENT_EVAL_BOUNDS_EN
      ,
      .bounds_err   (bounds_err)
`endif
   );

   // Single-cycle-latency read ports; data only changes when read is enabled.
   always @(posedge clk) begin
      if (ea_re) ea_data <= e_a[ea_addr[3:0]];
      if (eb_re) eb_data <= e_b[eb_addr[3:0]];
      if (px_re) px_data <= pos_x[px_addr[3:0]];
      if (py_re) py_data <= pos_y[py_addr[3:0]];
   end

   task automatic chk(input string tag, input logic signed [DW-1:0] obs,
                      input logic signed [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Scores the current edge list and positions straight from the wirelength rules.
   task automatic model(output int c, output int m, output bit u, output bit o);
      c = 0; m = 0; u = 0; o = 0;
`ifdef PLACEMENT_EVAL_BOUNDS_EN
      exp_bnd = 0;
`endif
      for (int k = 0; k < N_EDGE; k++) begin
         int  xs[4];
         bit  un, oob;
         int  len;
         xs  = '{pos_x[e_a[k]], pos_y[e_a[k]], pos_x[e_b[k]], pos_y[e_b[k]]};
         un  = 0;
         oob = 0;
         foreach (xs[j]) begin
            if (xs[j] == -1) un = 1;
            else if (xs[j] < 0 || xs[j] >= N0) oob = 1;
         end
`ifdef PLACEMENT_EVAL_BOUNDS_EN
         if (oob) exp_bnd = 1;
`else
         oob = 0;
`endif
         if (un) u = 1;
         else if (xs[0] == xs[2] && xs[1] == xs[3]) o = 1;
         else if (!oob) begin
            len = iabs(xs[0] - xs[2]) + iabs(xs[1] - xs[3]) - 1;
            c  += len;
            if (len > m) m = len;
         end
      end
   endtask

   task automatic set_basic();
      for (int k = 0; k < 16; k++) begin
         pos_x[k] = 1; pos_y[k] = 1; e_a[k] = 0; e_b[k] = 0;
      end
      pos_x[0] = 0; pos_y[0] = 0;
      pos_x[1] = 0; pos_y[1] = 1;
      pos_x[2] = 2; pos_y[2] = 3;
      e_a[0] = 0; e_b[0] = 1;
      e_a[1] = 1; e_b[1] = 2;
      e_a[2] = 0; e_b[2] = 2;
   endtask

   // One full run; optionally pulses start again at cycle restart_at of the run.
   task automatic run(input string tag, input int restart_at);
      int c, m, cyc, busy_low;
      bit u, o;
      model(c, m, u, o);
      @(negedge clk);
      chk({tag, "/idle_done"}, done, 0);
      chk({tag, "/idle_busy"}, busy, 0);
      start = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      cyc      = 1;
      busy_low = (busy !== 1'b1) ? 1 : 0;
      while (done !== 1'b1 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         start = (cyc == restart_at);
         if (cyc < LAT && busy !== 1'b1) busy_low++;
      end
      start = 1'b0;
      chk({tag, "/latency"}, cyc, LAT);
      chk({tag, "/busy_gaps"}, busy_low, 0);
      chk({tag, "/busy_at_done"}, busy, 0);
      chk({tag, "/cost"}, cost, c);
      chk({tag, "/max_len"}, max_len, m);
      chk({tag, "/unplaced"}, unplaced_err, u);
      chk({tag, "/overlap"}, overlap_err, o);
`ifdef PLACEMENT_EVAL_BOUNDS_EN
      chk({tag, "/bounds"}, bounds_err, exp_bnd);
`endif
   endtask

   initial begin
      int r, dpulses, len0;
      // start asserted together with reset: reset must win
      reset = 1'b0;
      start = 1'b1;
      set_basic();
      repeat (3) @(negedge clk);
      chk("rst/busy", busy, 0);
      chk("rst/done", done, 0);
      chk("rst/cost", cost, 0);
      chk("rst/max_len", max_len, 0);
      chk("rst/unplaced", unplaced_err, 0);
      chk("rst/overlap", overlap_err, 0);
      chk("rst/ea_re", ea_re, 0);
      chk("rst/px_re", px_re, 0);
      chk("rst/ea_addr", ea_addr, 0);
      start = 1'b0;
      reset = 1'b1;

      run("basic", 0);

      pos_x[2] = -1;
      run("unplaced", 0);

      set_basic();
      for (int k = 0; k < 3; k++) begin
         pos_x[k] = 3; pos_y[k] = 3;
      end
      run("overlap", 0);

      set_basic();
      run("restart", 5);
      run("b2b", 0);

      // Abort mid-run: first edge is nonzero so cost has moved before reset hits.
      e_a[0] = 0; e_b[0] = 2;
      e_a[2] = 0; e_b[2] = 1;
      len0 = iabs(pos_x[0] - pos_x[2]) + iabs(pos_y[0] - pos_y[2]) - 1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      chk("midrst/busy_before", busy, 1);
      chk("midrst/cost_before", cost, len0);
      reset = 1'b0;
      start = 1'b1;
      @(negedge clk);
      chk("midrst/busy", busy, 0);
      chk("midrst/done", done, 0);
      chk("midrst/cost", cost, 0);
      chk("midrst/max_len", max_len, 0);
      chk("midrst/ea_re", ea_re, 0);
      start   = 1'b0;
      reset   = 1'b1;
      dpulses = 0;
      repeat (60) begin
         @(negedge clk);
         if (done === 1'b1) dpulses++;
      end
      chk("midrst/no_done", dpulses, 0);
      run("after_reset", 0);

`ifdef PLACEMENT_EVAL_BOUNDS_EN
      set_basic();
      pos_x[2] = 4; pos_y[2] = 0;
      run("bounds", 0);
`endif

      for (int it = 0; it < 25; it++) begin
         for (int k = 0; k < 16; k++) begin
            r = $urandom_range(0, 19);
            pos_x[k] = (r == 0) ? -1 : (r == 1) ? N0 : (r == 2) ? -2 : $urandom_range(0, N0 - 1);
            r = $urandom_range(0, 19);
            pos_y[k] = (r == 0) ? -1 : (r == 1) ? N0 : $urandom_range(0, N0 - 1);
            e_a[k] = $urandom_range(0, 15);
            e_b[k] = $urandom_range(0, 15);
         end
         run($sformatf("rand%0d", it), 0);
      end

      @(negedge clk);
      chk("final/done_low", done, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
